// File: rtl/gpio_arb_pkg.sv
// Shared types and register offsets for the two-master GPIO arbiter.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] GPIO_DATA_OFF = 4'h0;
    localparam logic [3:0] GPIO_DIR_OFF  = 4'h4;
    localparam logic [3:0] GPIO_IN_OFF   = 4'h8;

endpackage

// File: rtl/gpio_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to ptr.
module gpio_arb_rr (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant
);

    always_comb begin
        // NOTE: grant gets a default before the ifs so every path assigns it and no latch is inferred.
        grant = ptr;
        if (req == 2'b01) begin
            grant = 1'b0;
        end else if (req == 2'b10) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/gpio_arbiter.sv
// Arbitrates two register masters onto one GPIO register port, one access per 3 cycles.
// Define GPIO_ARB_ERR_EN to reject unmapped offsets and writes to the input register.
module gpio_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              gpio_we,
    output logic              gpio_re,
    output logic [ADDR_W-1:0] gpio_addr,
    output logic [DATA_W-1:0] gpio_wdata,
    input  logic [DATA_W-1:0] gpio_rdata
);

    state_t            state_q;
    logic              ptr_q;
    logic              win_q;
    logic              we_q;
    logic              err_q;
    logic [1:0]        ack_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;
    logic [DATA_W-1:0] resp_data;

    gpio_arb_rr u_rr (
        .req   ({m1_req, m0_req}),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign sel_we    = grant ? m1_we    : m0_we;
    assign sel_addr  = grant ? m1_addr  : m0_addr;
    assign sel_wdata = grant ? m1_wdata : m0_wdata;

`ifdef GPIO_ARB_ERR_EN
    assign sel_bad = !((sel_addr == ADDR_W'(GPIO_DATA_OFF)) ||
                       (sel_addr == ADDR_W'(GPIO_DIR_OFF))  ||
                       ((sel_addr == ADDR_W'(GPIO_IN_OFF)) && !sel_we));
    assign m0_err  = ack_q[0] & err_q;
    assign m1_err  = ack_q[1] & err_q;
`else
    assign sel_bad = 1'b0;
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
`endif

    // gpio_rdata only arrives during RESP, so the acked master sees it directly; others see their last capture.
    assign resp_data = (we_q || err_q) ? '0 : gpio_rdata;
    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_rdata  = ack_q[0] ? resp_data : rdata0_q;
    assign m1_rdata  = ack_q[1] ? resp_data : rdata1_q;

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            gpio_we    <= 1'b0;
            gpio_re    <= 1'b0;
            gpio_addr  <= '0;
            gpio_wdata <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        win_q      <= grant;
                        we_q       <= sel_we;
                        err_q      <= sel_bad;
                        gpio_addr  <= sel_addr;
                        gpio_wdata <= sel_wdata;
                        gpio_we    <= sel_we & ~sel_bad;
                        gpio_re    <= ~sel_we & ~sel_bad;
                        ptr_q      <= ~grant;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gpio_we        <= 1'b0;
                    gpio_re        <= 1'b0;
                    ack_q[win_q]   <= 1'b1;
                    state_q        <= ST_RESP;
                end
                ST_RESP: begin
                    ack_q <= 2'b00;
                    if (win_q) begin
                        rdata1_q <= resp_data;
                    end else begin
                        rdata0_q <= resp_data;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Self-checking bench for gpio_arbiter: directed vector table, corner sequences, randomized traffic vs a timeline model.
module tb_gpio_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_v;
    logic [1:0]  we_v;
    logic [3:0]  addr_v [2];
    logic [31:0] wdata_v [2];
    logic [1:0]  ack_v;
    logic [1:0]  err_v;
    logic [31:0] rd_a [2];
    logic        gpio_we;
    logic        gpio_re;
    logic [3:0]  gpio_addr;
    logic [31:0] gpio_wdata;
    logic [31:0] gpio_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpio_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (req_v[0]),
        .m0_we      (we_v[0]),
        .m0_addr    (addr_v[0]),
        .m0_wdata   (wdata_v[0]),
        .m0_ack     (ack_v[0]),
        .m0_rdata   (rd_a[0]),
        .m0_err     (err_v[0]),
        .m1_req     (req_v[1]),
        .m1_we      (we_v[1]),
        .m1_addr    (addr_v[1]),
        .m1_wdata   (wdata_v[1]),
        .m1_ack     (ack_v[1]),
        .m1_rdata   (rd_a[1]),
        .m1_err     (err_v[1]),
        .gpio_we    (gpio_we),
        .gpio_re    (gpio_re),
        .gpio_addr  (gpio_addr),
        .gpio_wdata (gpio_wdata),
        .gpio_rdata (gpio_rdata)
    );

    typedef struct {
        bit          who;
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] grd;
        bit          exp_we;
        bit          exp_re;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_v      = 2'b00;
        we_v       = 2'b00;
        addr_v[0]  = 4'h0;
        addr_v[1]  = 4'h0;
        wdata_v[0] = 32'h0;
        wdata_v[1] = 32'h0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    function automatic bit bad_access(input bit we, input logic [3:0] a);
`ifdef GPIO_ARB_ERR_EN
        return !((a == 4'h0) || (a == 4'h4) || ((a == 4'h8) && !we));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 4'h0;
            1:       return 4'h4;
            2:       return 4'h8;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    // Timeline model: a grant at edge t puts the strobe after t, the ack after t+1, and frees the port at t+3.
    bit          busy;
    int          t_edge;
    int          t_who;
    bit          t_we;
    bit          t_bad;
    int          pref;
    logic [31:0] exp_rd [2];
    logic [3:0]  exp_ga;
    logic [31:0] exp_gw;

    initial begin
        reset_dut();
        gpio_rdata = 32'h0;
        reset = 1'b0;
        #1;
        check("rst_gpio_we", gpio_we, 0);
        check("rst_gpio_re", gpio_re, 0);
        check("rst_gpio_addr", gpio_addr, 0);
        check("rst_gpio_wdata", gpio_wdata, 0);
        check("rst_ack", ack_v, 0);
        check("rst_err", err_v, 0);
        check("rst_m0_rdata", rd_a[0], 0);
        check("rst_m1_rdata", rd_a[1], 0);
        reset_dut();

        vecs[0] = '{0, 1, 4'h4, 32'h0000000F, 32'h0,        1, 0, 32'h0,        0};
        vecs[1] = '{1, 0, 4'h8, 32'h0,        32'h000000A0, 0, 1, 32'h000000A0, 0};
        vecs[2] = '{0, 0, 4'h0, 32'h0,        32'h12345678, 0, 1, 32'h12345678, 0};
        vecs[3] = '{1, 1, 4'h0, 32'hDEADBEEF, 32'h00000055, 1, 0, 32'h0,        0};
`ifdef GPIO_ARB_ERR_EN
        vecs[4] = '{0, 1, 4'h8, 32'h00000001, 32'h00000077, 0, 0, 32'h0,        1};
        vecs[5] = '{1, 0, 4'hC, 32'h0,        32'h00000099, 0, 0, 32'h0,        1};
`else
        vecs[4] = '{0, 1, 4'h8, 32'h00000001, 32'h00000077, 1, 0, 32'h0,        0};
        vecs[5] = '{1, 0, 4'hC, 32'h0,        32'h00000099, 0, 1, 32'h00000099, 0};
`endif
        vecs[6] = '{0, 0, 4'h4, 32'h0,        32'hCAFE0001, 0, 1, 32'hCAFE0001, 0};

        foreach (vecs[n]) begin
            vec_t v;
            v = vecs[n];
            gpio_rdata       = v.grd;
            we_v[v.who]      = v.we;
            addr_v[v.who]    = v.addr;
            wdata_v[v.who]   = v.wdata;
            req_v[v.who]     = 1'b1;
            tick();
            check("vec_issue_we", gpio_we, v.exp_we);
            check("vec_issue_re", gpio_re, v.exp_re);
            check("vec_issue_addr", gpio_addr, v.addr);
            check("vec_issue_wdata", gpio_wdata, v.wdata);
            check("vec_issue_ack", ack_v, 0);
            tick();
            check("vec_resp_strobes", {gpio_we, gpio_re}, 0);
            check("vec_resp_ack", ack_v[v.who], 1);
            check("vec_resp_other_ack", ack_v[!v.who], 0);
            check("vec_resp_rdata", rd_a[v.who], v.exp_rd);
            check("vec_resp_err", err_v[v.who], v.exp_err);
            req_v[v.who] = 1'b0;
            tick();
            check("vec_idle_ack", ack_v, 0);
            check("vec_idle_rdata_hold", rd_a[v.who], v.exp_rd);
        end

        // Both masters hold requests from reset: grants alternate m0, m1, m0.
        reset_dut();
        gpio_rdata = 32'h00000011;
        addr_v[0]  = 4'h0;
        addr_v[1]  = 4'h4;
        req_v      = 2'b11;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("rr_m0_ack", ack_v[0], (k == 2 || k == 8) ? 1 : 0);
            check("rr_m1_ack", ack_v[1], (k == 5) ? 1 : 0);
        end
        req_v = 2'b00;
        repeat (3) tick();

        // Request dropped after latching still completes.
        we_v[1]   = 1'b0;
        addr_v[1] = 4'h8;
        req_v[1]  = 1'b1;
        tick();
        req_v[1] = 1'b0;
        tick();
        check("drop_ack", ack_v[1], 1);
        tick();
        check("drop_ack_clear", ack_v[1], 0);

        // Reset during ISSUE: strobes drop at once, no ack, pointer back to m0.
        reset_dut();
        we_v[0]    = 1'b1;
        addr_v[0]  = 4'h4;
        wdata_v[0] = 32'h0000000F;
        req_v[0]   = 1'b1;
        tick();
        check("abort_we_before", gpio_we, 1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_we", gpio_we, 0);
        check("abort_re", gpio_re, 0);
        check("abort_addr", gpio_addr, 0);
        req_v = 2'b00;
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_ack", ack_v, 0);
        end
        we_v  = 2'b00;
        req_v = 2'b11;
        tick();
        tick();
        check("abort_ptr_m0", ack_v, 2'b01);
        req_v = 2'b00;
        repeat (2) tick();

        // Randomized traffic against the timeline model.
        reset_dut();
        busy      = 1'b0;
        t_edge    = 0;
        t_who     = 0;
        t_we      = 1'b0;
        t_bad     = 1'b0;
        pref      = 0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        exp_ga    = 4'h0;
        exp_gw    = 32'h0;
        for (int k = 1; k <= 1500; k++) begin
            bit strobe;
            bit ack_e [2];
            tick();
            if (busy && k >= t_edge + 3) busy = 1'b0;
            if (!busy && (req_v != 2'b00)) begin
                int w;
                w      = (req_v == 2'b11) ? pref : (req_v[1] ? 1 : 0);
                busy   = 1'b1;
                t_edge = k;
                t_who  = w;
                t_we   = we_v[w];
                t_bad  = bad_access(we_v[w], addr_v[w]);
                exp_ga = addr_v[w];
                exp_gw = wdata_v[w];
                pref   = 1 - w;
            end
            gpio_rdata = $urandom;
            #1;
            strobe = busy && (k == t_edge);
            check("rnd_gpio_we", gpio_we, strobe && t_we && !t_bad);
            check("rnd_gpio_re", gpio_re, strobe && !t_we && !t_bad);
            check("rnd_gpio_addr", gpio_addr, exp_ga);
            check("rnd_gpio_wdata", gpio_wdata, exp_gw);
            for (int i = 0; i < 2; i++) begin
                logic [31:0] rd_e;
                ack_e[i] = busy && (k == t_edge + 1) && (t_who == i);
                rd_e     = ack_e[i] ? ((t_we || t_bad) ? 32'h0 : gpio_rdata) : exp_rd[i];
                check("rnd_ack", ack_v[i], ack_e[i]);
                check("rnd_rdata", rd_a[i], rd_e);
                check("rnd_err", err_v[i], ack_e[i] && t_bad);
                if (ack_e[i]) exp_rd[i] = rd_e;
            end
            for (int i = 0; i < 2; i++) begin
                bit owned;
                owned = busy && (t_who == i);
                if (req_v[i]) begin
                    if (ack_e[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            req_v[i] = 1'b0;
                        end else begin
                            we_v[i]    = 1'($urandom_range(0, 1));
                            addr_v[i]  = rand_addr();
                            wdata_v[i] = $urandom;
                        end
                    end else if (owned && (k == t_edge) && ($urandom_range(0, 3) == 0)) begin
                        req_v[i] = 1'b0;
                    end
                end else if (!(owned && k < t_edge + 2) && ($urandom_range(0, 2) == 0)) begin
                    we_v[i]    = 1'($urandom_range(0, 1));
                    addr_v[i]  = rand_addr();
                    wdata_v[i] = $urandom;
                    req_v[i]   = 1'b1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
